// File: rtl/player_motion.sv
// Timed player movement with an external collision query before each committed step.
// Optional macro PLAYER_MOTION_WRAP_EN selects toroidal wrap instead of clamping at the bounds.
module player_motion #(
    parameter int POS_W     = 10,
    parameter int CLK_HZ    = 50_000_000,
    parameter int UPDATE_HZ = 100,
    parameter int STEP      = 1,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 620,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 460,
    parameter int X_INIT    = 310,
    parameter int Y_INIT    = 230
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             left,
    input  logic             right,
    input  logic             up,
    input  logic             down,
    input  logic             flip_vert,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             coll_req,
    output logic [POS_W-1:0] coll_x,
    output logic [POS_W-1:0] coll_y,
    input  logic             coll_ack,
    input  logic             coll_blocked,
    output logic             moved,
    output logic             busy
);

    localparam int DIV   = CLK_HZ / UPDATE_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    // Two guard bits: one for the sign, one so pos+STEP near 2^POS_W cannot overflow.
    localparam int CW    = POS_W + 2;

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DIV - 1);
    localparam logic signed [CW-1:0] STEP_S   = CW'(STEP);
    localparam logic signed [CW-1:0] ONE_S    = CW'(1);
    localparam logic signed [CW-1:0] AX_MIN [2] = '{CW'(X_MIN), CW'(Y_MIN)};
    localparam logic signed [CW-1:0] AX_MAX [2] = '{CW'(X_MAX), CW'(Y_MAX)};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PROPOSE,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             blocked_reg;

    logic signed [CW-1:0] delta    [2];
    logic signed [CW-1:0] dy_raw;
    logic [POS_W-1:0]     pos_cur  [2];
    logic [POS_W-1:0]     cand_pos [2];
    logic                 no_motion;

    function automatic logic [POS_W-1:0] bound_axis(
        input logic signed [CW-1:0] c,
        input logic signed [CW-1:0] lo,
        input logic signed [CW-1:0] hi
    );
        logic signed [CW-1:0] r;
        r = c;
`ifdef PLAYER_MOTION_WRAP_EN
        if (c > hi)
            r = lo + (c - hi - ONE_S);
        else if (c < lo)
            r = hi - (lo - c - ONE_S);
`else
        if (c > hi)
            r = hi;
        else if (c < lo)
            r = lo;
`endif
        return POS_W'(r);
    endfunction

    // Opposing keys on one axis cancel; flip_vert mirrors the vertical request.
    always_comb begin
        delta[0] = '0;
        if (right && !left)
            delta[0] = STEP_S;
        else if (left && !right)
            delta[0] = -STEP_S;

        dy_raw = '0;
        if (down && !up)
            dy_raw = STEP_S;
        else if (up && !down)
            dy_raw = -STEP_S;
        delta[1] = flip_vert ? -dy_raw : dy_raw;
    end

    assign pos_cur[0] = x_pos;
    assign pos_cur[1] = y_pos;
    assign no_motion  = (delta[0] == '0) && (delta[1] == '0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            assign cand_pos[gi] = bound_axis($signed({2'b00, pos_cur[gi]}) + delta[gi],
                                             AX_MIN[gi], AX_MAX[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            blocked_reg <= 1'b0;
            x_pos       <= POS_W'(X_INIT);
            y_pos       <= POS_W'(Y_INIT);
            coll_x      <= POS_W'(X_INIT);
            coll_y      <= POS_W'(Y_INIT);
            coll_req    <= 1'b0;
            moved       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            moved <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    cnt_reg <= '0;
                    if (start)
                        state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (start) begin
                            state_reg <= S_PROPOSE;
                            busy      <= 1'b1;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_PROPOSE: begin
                    if (no_motion) begin
                        state_reg <= S_WAIT;
                        busy      <= 1'b0;
                    end else begin
                        coll_x    <= cand_pos[0];
                        coll_y    <= cand_pos[1];
                        coll_req  <= 1'b1;
                        state_reg <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (coll_ack) begin
                        blocked_reg <= coll_blocked;
                        coll_req    <= 1'b0;
                        state_reg   <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // A clamped candidate equal to the current position is not a move.
                    if (!blocked_reg && ((coll_x != x_pos) || (coll_y != y_pos))) begin
                        x_pos <= coll_x;
                        y_pos <= coll_y;
                        moved <= 1'b1;
                    end
                    state_reg <= S_WAIT;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    coll_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Randomized bench for player_motion against a transaction-level position model.
// Honours PLAYER_MOTION_WRAP_EN the same way as the design.
module tb_player_motion;

    localparam int POS_W     = 10;
    localparam int CLK_HZ    = 1000;
    localparam int UPDATE_HZ = 100;
    localparam int STEP      = 1;
    localparam int X_MIN     = 0;
    localparam int X_MAX     = 620;
    localparam int Y_MIN     = 0;
    localparam int Y_MAX     = 460;
    localparam int X_INIT    = 310;
    localparam int Y_INIT    = 230;
    localparam int PERIOD    = CLK_HZ / UPDATE_HZ + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, flip_vert = 1'b0;
    logic coll_ack = 1'b0, coll_blocked = 1'b0;
    logic [POS_W-1:0] x_pos, y_pos, coll_x, coll_y;
    logic coll_req, moved, busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_x = X_INIT;
    int exp_y = Y_INIT;
    int move_cyc = 0;
    int prev_move_cyc = 0;

    always #5 clk = ~clk;

    player_motion #(
        .POS_W(POS_W), .CLK_HZ(CLK_HZ), .UPDATE_HZ(UPDATE_HZ), .STEP(STEP),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .X_INIT(X_INIT), .Y_INIT(Y_INIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .left(left), .right(right), .up(up), .down(down), .flip_vert(flip_vert),
        .x_pos(x_pos), .y_pos(y_pos),
        .coll_req(coll_req), .coll_x(coll_x), .coll_y(coll_y),
        .coll_ack(coll_ack), .coll_blocked(coll_blocked),
        .moved(moved), .busy(busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic int bound_pos(input int c, input int lo, input int hi);
`ifdef PLAYER_MOTION_WRAP_EN
        if (c > hi) return lo + (c - hi - 1);
        if (c < lo) return hi - (lo - c - 1);
        return c;
`else
        if (c > hi) return hi;
        if (c < lo) return lo;
        return c;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        coll_ack = 1'b0;
        tick();
        tick();
        chk("rst_x", int'(x_pos), X_INIT);
        chk("rst_y", int'(y_pos), Y_INIT);
        chk("rst_cx", int'(coll_x), X_INIT);
        chk("rst_cy", int'(coll_y), Y_INIT);
        chk("rst_req", int'(coll_req), 0);
        chk("rst_moved", int'(moved), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        exp_x = X_INIT;
        exp_y = Y_INIT;
        start = 1'b1;
    endtask

    // One movement update: hold keys until the proposal, then answer the query after n_ack cycles.
    task automatic do_update(input bit r, input bit l, input bit u, input bit d,
                             input bit f, input bit blk, input int n_ack);
        int dx, dy, cx, cy, req_cyc;
        bit got, want_move;
        right = r; left = l; up = u; down = d; flip_vert = f;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            coll_ack = ($urandom_range(0, 3) == 0);
            coll_blocked = 1'($urandom_range(0, 1));
            tick();
            if (busy) got = 1'b1;
        end
        coll_ack = 1'b0;
        coll_blocked = blk;
        chk("propose_reached", int'(got), 1);
        if (!got) return;

        dx = STEP * (int'(r) - int'(l));
        dy = STEP * (int'(d) - int'(u));
        if (f) dy = -dy;
        cx = bound_pos(exp_x + dx, X_MIN, X_MAX);
        cy = bound_pos(exp_y + dy, Y_MIN, Y_MAX);
        tick();

        // Keys and start wiggle after the proposal; the in-flight update must ignore them.
        right = 1'($urandom_range(0, 1));
        left = 1'($urandom_range(0, 1));
        up = 1'($urandom_range(0, 1));
        down = 1'($urandom_range(0, 1));
        flip_vert = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));

        if (dx == 0 && dy == 0) begin
            chk("noquery_req", int'(coll_req), 0);
            chk("noquery_busy", int'(busy), 0);
            chk("noquery_moved", int'(moved), 0);
            start = 1'b1;
            $display("upd r%0d l%0d u%0d d%0d f%0d: no motion, x=%0d y=%0d",
                     r, l, u, d, f, x_pos, y_pos);
            tick();
            return;
        end

        req_cyc = 0;
        for (int k = 1; k <= n_ack; k++) begin
            if (coll_req) req_cyc++;
            chk("check_busy", int'(busy), 1);
            chk("coll_x", int'(coll_x), cx);
            chk("coll_y", int'(coll_y), cy);
            if (k == n_ack) coll_ack = 1'b1;
            tick();
        end
        coll_ack = 1'b0;
        start = 1'b1;
        chk("req_cycles", req_cyc, n_ack);
        chk("req_drop", int'(coll_req), 0);
        tick();

        want_move = !blk && (cx != exp_x || cy != exp_y);
        if (want_move) begin
            exp_x = cx;
            exp_y = cy;
        end
        chk("moved", int'(moved), int'(want_move));
        chk("x_pos", int'(x_pos), exp_x);
        chk("y_pos", int'(y_pos), exp_y);
        if (moved) begin
            prev_move_cyc = move_cyc;
            move_cyc = cyc;
        end
        $display("upd r%0d l%0d u%0d d%0d f%0d blk%0d ack%0d: cand=(%0d,%0d) x=%0d y=%0d moved=%0d",
                 r, l, u, d, f, blk, n_ack, cx, cy, x_pos, y_pos, moved);
        tick();
        chk("moved_pulse", int'(moved), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, guard;

        do_reset();

        // Basic right step and update period with immediate ack.
        do_update(1, 0, 0, 0, 0, 0, 1);
        chk("first_step_x", int'(x_pos), X_INIT + 1);
        do_update(1, 0, 0, 0, 0, 0, 1);
        chk("period", move_cyc - prev_move_cyc, PERIOD);

        // Vertical inversion and cancelled horizontal keys.
        do_reset();
        do_update(0, 0, 1, 0, 1, 0, 1);
        chk("flip_up_y", int'(y_pos), Y_INIT + 1);
        do_update(0, 0, 1, 0, 0, 0, 1);
        do_update(0, 0, 1, 0, 0, 0, 1);
        chk("up_y", int'(y_pos), Y_INIT - 1);
        do_update(1, 1, 0, 0, 0, 0, 1);

        // Slow, blocking collision response.
        do_reset();
        do_update(1, 0, 0, 0, 0, 1, 5);
        chk("blocked_x", int'(x_pos), X_INIT);

        // Reset in the middle of a query, then start dropped before terminal count.
        right = 1'b1; left = 1'b0; up = 1'b0; down = 1'b0; flip_vert = 1'b0;
        guard = 0;
        while (!busy && guard < 40) begin tick(); guard++; end
        tick();
        chk("mid_check_req", int'(coll_req), 1);
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        exp_x = X_INIT;
        exp_y = Y_INIT;
        chk("rstchk_req", int'(coll_req), 0);
        chk("rstchk_busy", int'(busy), 0);
        chk("rstchk_x", int'(x_pos), X_INIT);
        chk("rstchk_y", int'(y_pos), Y_INIT);
        busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy || coll_req) busy_cnt++;
        end
        chk("idle_hold", busy_cnt, 0);
        start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (busy || coll_req) busy_cnt++;
        end
        chk("start_low_tc", busy_cnt, 0);
        start = 1'b1;

        // Random traffic.
        for (int t = 0; t < 150; t++) begin
            do_update(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      int'($urandom_range(1, 5)));
        end

        // Drive to the right edge, then push against it.
        guard = 0;
        while (exp_x != X_MAX && guard < 700) begin
            do_update(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1);
            guard++;
        end
        chk("at_xmax", int'(x_pos), X_MAX);
        do_update(1, 0, 0, 0, 0, 0, 1);
`ifdef PLAYER_MOTION_WRAP_EN
        chk("edge_right_x", int'(x_pos), X_MIN);
`else
        chk("edge_right_x", int'(x_pos), X_MAX);
`endif

        // Drive to the top edge (y = 0), then push against it.
        guard = 0;
        while (exp_y != Y_MIN && guard < 700) begin
            do_update(0, 0, 1, 0, 0, ($urandom_range(0, 15) == 0), 1);
            guard++;
        end
        chk("at_ymin", int'(y_pos), Y_MIN);
        do_update(0, 0, 1, 0, 0, 0, 1);
`ifdef PLAYER_MOTION_WRAP_EN
        chk("edge_top_y", int'(y_pos), Y_MAX);
`else
        chk("edge_top_y", int'(y_pos), Y_MIN);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
